// File: rtl/skid_buffer_if.sv
// Valid/ready handshake bundle for the skid buffer: producer side (in_*),
// consumer side (out_*) and occupancy. The buffer is the slave; the driver of both sides is the master.
interface skid_buffer_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: every output (in_ready, out_valid,
// out_data, count) comes straight from a flop, so no combinational path crosses the stage.
module skid_buffer #(
  parameter int unsigned WIDTH = 1
) (
  input logic           clk,
  input logic           rst,
  skid_buffer_if.slave  bus
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             in_ready_q;
  logic             in_ready_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             accept;
  logic             consume;

  // Handshakes use only the registered ready/valid, keeping outputs free of input paths.
  assign accept  = bus.in_valid & in_ready_q;
  assign consume = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    count_d     = CW'(0);

    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && consume) begin
          main_d = bus.in_data;
        end else if (accept) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the producer side is ignored.
        if (consume) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    case (state_d)
      BUSY:    count_d = CW'(1);
      FULL:    count_d = CW'(2);
      default: count_d = CW'(0);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= WIDTH'(0);
      skid_q      <= WIDTH'(0);
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= CW'(0);
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and randomized checks of skid_buffer (WIDTH=8) against hand-computed
// expectations and a reference queue.
module tb_skid_buffer;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  skid_buffer_if #(.WIDTH(WIDTH)) bus ();

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    step();
    total++;
    if (bus.count !== 2'd1) $display("FAIL reset_prefill count got %0d exp 1", bus.count);
    else passed++;
    // Asynchronous assertion mid-cycle, no clock edge involved.
    bus.in_data = 8'h05;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_async out_valid got %b exp 0", bus.out_valid);
    else passed++;
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_async in_ready got %b exp 0", bus.in_ready);
    else passed++;
    total++;
    if (bus.count !== 2'd0) $display("FAIL reset_async count got %0d exp 0", bus.count);
    else passed++;
    total++;
    if (bus.out_data !== 8'h00) $display("FAIL reset_async out_data got %h exp 00", bus.out_data);
    else passed++;
    step();
    rst = 1'b0;
    step();
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release in_ready got %b exp 1", bus.in_ready);
    else passed++;
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
      $display("FAIL reset_release_nocapture out_valid/count got %b/%0d exp 0/0", bus.out_valid, bus.count);
    else passed++;
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i))
        $display("FAIL stream_beat%0d valid/data got %b/%h exp 1/%h", i, bus.out_valid, bus.out_data, 8'(i));
      else passed++;
      total++;
      if (bus.count !== 2'd1 || bus.in_ready !== 1'b1)
        $display("FAIL stream_occ%0d count/in_ready got %0d/%b exp 1/1", i, bus.count, bus.in_ready);
      else passed++;
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
      $display("FAIL stream_drain valid/count got %b/%0d exp 0/0", bus.out_valid, bus.count);
    else passed++;
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA0;
    step();
    bus.out_ready = 1'b0;
    bus.in_data   = 8'hA1;
    step();
    bus.in_data = 8'hA2;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.count !== 2'd2 || bus.in_ready !== 1'b0)
        $display("FAIL stall_full%0d count/in_ready got %0d/%b exp 2/0", i, bus.count, bus.in_ready);
      else passed++;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0)
        $display("FAIL stall_hold%0d valid/data got %b/%h exp 1/a0", i, bus.out_valid, bus.out_data);
      else passed++;
      step();
    end
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.out_data !== 8'hA1 || bus.count !== 2'd1 || bus.in_ready !== 1'b1)
      $display("FAIL stall_release data/count/in_ready got %h/%0d/%b exp a1/1/1", bus.out_data, bus.count, bus.in_ready);
    else passed++;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA2 || bus.count !== 2'd1)
      $display("FAIL stall_last valid/data/count got %b/%h/%0d exp 1/a2/1", bus.out_valid, bus.out_data, bus.count);
    else passed++;
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
      $display("FAIL stall_drain valid/count got %b/%0d exp 0/0", bus.out_valid, bus.count);
    else passed++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hB0;
    step();
    bus.in_data = 8'hB1;
    step();
    bus.in_data = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.count !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 8'hB0)
        $display("FAIL bp_hold%0d count/in_ready/data got %0d/%b/%h exp 2/0/b0", i, bus.count, bus.in_ready, bus.out_data);
      else passed++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.out_data !== 8'hB1 || bus.count !== 2'd1)
      $display("FAIL bp_drain1 data/count got %h/%0d exp b1/1", bus.out_data, bus.count);
    else passed++;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
      $display("FAIL bp_drain2 valid/count got %b/%0d exp 0/0", bus.out_valid, bus.count);
    else passed++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic             hold;
    logic [WIDTH-1:0] held;
    logic             acc;
    logic             con;
    for (int n = 0; n < 10000; n++) begin
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(9) < 6);
      acc  = bus.in_valid && bus.in_ready;
      con  = bus.out_valid && bus.out_ready;
      hold = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (con) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL rnd_pop%0d spurious beat %h exp none", n, bus.out_data);
        end else begin
          if (bus.out_data !== q[0]) $display("FAIL rnd_pop%0d data got %h exp %h", n, bus.out_data, q[0]);
          else passed++;
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back(bus.in_data);
      step();
      total++;
      if (bus.count !== 2'(q.size()) || bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() != 2))
        $display("FAIL rnd_state%0d count/valid/in_ready got %0d/%b/%b exp occupancy %0d", n, bus.count, bus.out_valid, bus.in_ready, q.size());
      else passed++;
      if (q.size() != 0) begin
        total++;
        if (bus.out_data !== q[0]) $display("FAIL rnd_head%0d data got %h exp %h", n, bus.out_data, q[0]);
        else passed++;
      end
      if (hold) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held)
          $display("FAIL rnd_stable%0d valid/data got %b/%h exp 1/%h", n, bus.out_valid, bus.out_data, held);
        else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC0;
    step();
    bus.in_data = 8'hC1;
    step();
    total++;
    if (bus.count !== 2'd2) $display("FAIL mid_fill count got %0d exp 2", bus.count);
    else passed++;
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.count !== 2'd0 || bus.out_data !== 8'h00)
      $display("FAIL mid_reset valid/in_ready/count/data got %b/%b/%0d/%h exp 0/0/0/00", bus.out_valid, bus.in_ready, bus.count, bus.out_data);
    else passed++;
    step();
    rst = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.count !== 2'd1)
      $display("FAIL mid_first valid/data/count got %b/%h/%0d exp 1/3c/1", bus.out_valid, bus.out_data, bus.count);
    else passed++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
      $display("FAIL mid_drain valid/count got %b/%0d exp 0/0 (stale beat delivered)", bus.out_valid, bus.count);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
# skid_buffer

Two-entry valid/ready skid buffer that registers both the forward path (valid/data) and the backward path (ready) between a producer and a consumer. It sits directly upstream of the enable-gated data register: `out_valid & out_ready` forms that register's `en` and `out_data` its `din`. This lets a pipeline stage accept a stall without a combinational ready path across the stage boundary.

## Interface
- `WIDTH`, default 1, payload width in bits (≥1).
- `clk`  input  1  rising-edge clock; all state updates on posedge.
- `rst`  input  1  reset: one clock; reset is asynchronous and active-high.
- `in_valid`  input  1  producer has a beat on `in_data`.
- `in_data`  input  WIDTH  producer payload.
- `in_ready`  output  1  buffer can accept; driven directly from a flop.
- `out_valid`  output  1  buffer presents a beat on `out_data`; driven directly from a flop.
- `out_data`  output  WIDTH  payload to the consumer; driven directly from a flop.
- `out_ready`  input  1  consumer accepts the presented beat.
- `count`  output  2  occupancy, 0..2; driven directly from a flop.

## Operation
- Storage: main register (drives `out_data`) and skid register. Beat accepted on input when `in_valid & in_ready`; beat consumed on output when `out_valid & out_ready`.
- States: EMPTY (count 0), BUSY (main full, count 1), FULL (main + skid full, count 2).
- EMPTY: accept -> main <= in_data, go BUSY. No accept -> stay.
- BUSY: accept & consume -> main <= in_data, stay BUSY. Accept, no consume -> skid <= in_data, go FULL. Consume, no accept -> go EMPTY. Neither -> stay.
- FULL: `in_ready`=0, `in_valid` ignored. Consume -> main <= skid, go BUSY. No consume -> stay.
- `in_ready` = registered (next_state != FULL); `out_valid` = registered (next_state != EMPTY); `count` = registered encoding of next_state.
- Ordering: strict FIFO; beats never dropped, duplicated or reordered.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold unchanged.
- `out_valid` never depends on `out_ready` combinationally; `in_ready` never depends on `in_valid` or `out_ready` combinationally.
- Skid register contents are don't-care when not FULL; main register contents are don't-care when EMPTY. Payload is not modified; no arithmetic on data.

## Timing
- Reset (async assert): state EMPTY, `out_valid`=0, `in_ready`=0, `count`=0, `out_data`=0, skid=0. All take effect immediately on `rst` rising, without a clock edge.
- First posedge after `rst` deasserts: `in_ready` -> 1. No beat is accepted on that edge.
- Latency: a beat accepted at edge N is on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1) when the buffer was EMPTY, or when it was BUSY and the presented beat was consumed at the same edge N.
- Throughput: 1 beat/cycle sustained with `out_ready` held high.
- Stall: `out_ready` drops while streaming -> one more beat is absorbed into skid, then `in_ready`=0 from the next cycle.
- Release: `out_ready` rises in FULL -> skid moves to main at that edge, and `in_ready`=1 the following cycle. No bubble appears on the output.
- Simultaneous accept+consume in BUSY: count stays 1, and the output updates to the new beat.
- Reset mid-transfer: all buffered beats are discarded and outputs return immediately to their reset values.

## Test plan
- Reset: assert `rst` with `in_valid`=1 and `in_data`=0x5 -> `out_valid`=0, `in_ready`=0, `count`=0 with no clock needed. After deassert, `in_ready`=1 one edge later, and no beat is captured.
- Streaming, WIDTH=8: send 0x01..0x10 back-to-back with `out_ready`=1 -> outputs 0x01..0x10 in order, 1-cycle latency, no gaps, `count`=1 throughout.
- Stall: stream 0xA0, 0xA1, 0xA2, dropping `out_ready` while 0xA0 is presented -> `count`=2, `in_ready`=0, and `out_data` held at 0xA0. Raising `out_ready` -> 0xA0, 0xA1, 0xA2 delivered in order with no loss.
- Backpressure hold: FULL with `in_valid`=1 and `in_data`=0xFF for 10 cycles -> 0xFF is never captured and the state is unchanged.
- Random: random `in_valid`/`out_ready` for 10k cycles against a reference queue -> exact match, `out_data` stable under stall, `count` equal to the model's occupancy.
- Mid-operation reset: assert `rst` while FULL -> outputs reset immediately. The next beat after release (0x3C) is the first one output.
